debounce_multi: RTL and testbench
=================================

// Module: debounce_multi
// PURPOSE
//  NUM_CH-channel switch/button debouncer, parametrised successor of the single-channel debouncer.
//  Per channel: metastability synchroniser, stability counter, registered level output, and
//  one-cycle rise/fall event pulses. Sits between board switch/button pins and control FSMs
//  (e.g. display mode/digit select). Optional hold-to-repeat for buttons.
// PARAMETERS
//  NUM_CH         4         number of independent channels (>=1)
//  DEBOUNCE_LIMIT 2000000   consecutive stable cycles required to accept a change (>=1; 20 ms @ 100 MHz)
//  SYNC_STAGES    2         synchroniser flops per channel (>=2)
//  REPEAT_DELAY   50000000  cycles held high before first repeat pulse (>=1; macro only)
//  REPEAT_RATE    10000000  cycles between subsequent repeat pulses (>=1; macro only)
// PORTS
//  i_Clk     in   1       system clock
//  i_Rst_n   in   1       synchronous reset, active low
//  i_Switch  in   NUM_CH  raw asynchronous switch inputs, bit n = channel n
//  o_Switch  out  NUM_CH  debounced level
//  o_Rise    out  NUM_CH  1-cycle pulse when o_Switch[n] goes 0->1
//  o_Fall    out  NUM_CH  1-cycle pulse when o_Switch[n] goes 1->0
//  o_Repeat  out  NUM_CH  1-cycle auto-repeat pulse while held (0 without macro)
//  o_Busy    out  1       OR of all channels whose counter is non-zero (change pending)
// BEHAVIOUR
//  - One clock, i_Clk; reset synchronous, active low on i_Rst_n. All state changes on posedge i_Clk.
//  - Reset (i_Rst_n=0 at a posedge): sync flops, counters, o_Switch, o_Rise, o_Fall, o_Repeat,
//    o_Busy, repeat counters all <= 0. Reset mid-count discards pending change; no pulses emitted.
//  - Sync: s[n] = last stage of SYNC_STAGES-deep shift register on i_Switch[n]. Counter logic uses s only.
//  - Counter width CW = $clog2(DEBOUNCE_LIMIT+1). Per channel, each cycle:
//      s != o_Switch and cnt <  DEBOUNCE_LIMIT-1 : cnt <= cnt+1
//      s != o_Switch and cnt == DEBOUNCE_LIMIT-1 : o_Switch <= s; cnt <= 0; pulse Rise/Fall
//      s == o_Switch                             : cnt <= 0 (glitch cancels pending change)
//  - Latency: pin change held stable -> o_Switch changes SYNC_STAGES+DEBOUNCE_LIMIT cycles later.
//    DEBOUNCE_LIMIT=1: o_Switch follows s with one cycle delay.
//  - o_Rise[n]/o_Fall[n] registered, asserted exactly in the first cycle o_Switch[n] shows new
//    value; never both high; low in all other cycles.
//  - Channels fully independent; simultaneous changes on several channels each pulse normally.
//  - o_Busy registered: 1 in cycles where any channel cnt != 0.
//  - Counter never exceeds DEBOUNCE_LIMIT-1; no wrap-around.
// CONFIGURATION
//  Macro DEBOUNCE_MULTI_REPEAT_EN:
//  - Defined: per-channel repeat counter (width $clog2(max(REPEAT_DELAY,REPEAT_RATE)+1)).
//    Cleared whenever o_Switch[n]=0 or on o_Rise[n]. While o_Switch[n]=1: first o_Repeat[n]
//    pulse REPEAT_DELAY cycles after o_Rise[n], then every REPEAT_RATE cycles until release.
//    Release (o_Fall) stops repeats same cycle; no pulse coincides with o_Fall.
//  - Undefined: no repeat logic synthesised; o_Repeat tied to 0; REPEAT_* ignored.
// TESTING  (NUM_CH=2, DEBOUNCE_LIMIT=8, SYNC_STAGES=2, REPEAT_DELAY=20, REPEAT_RATE=5)
//  1 Reset: i_Rst_n=0 3 cycles, i_Switch=2'b11 -> all outputs 0 during and on first cycle after release.
//  2 Clean press: ch0 0->1 held -> o_Switch[0]=1 and o_Rise[0]=1 exactly 10 cycles later,
//    o_Rise width 1; ch1 untouched; o_Busy=1 during count.
//  3 Bounce: ch0 high 5 cycles, low 1, high held -> o_Switch[0] rises 10 cycles after last edge.
//  4 Short glitch: ch1 high 7 cycles then low -> no o_Switch/o_Rise/o_Fall change; o_Busy returns to 0.
//  5 Simultaneous: both ch 1->0 same cycle from debounced high -> o_Fall=2'b11 in one cycle, 10 later.
//  6 Repeat (macro on): hold ch0 60 cycles after o_Rise -> o_Repeat[0] at +20,+25,...,+55; none
//    after release. Macro off: o_Repeat stays 0.

Source files
------------

// File: rtl/debounce_multi.sv
// Multi-channel switch/button debouncer: per-channel synchroniser, stability counter,
// level output with rise/fall pulses. Define DEBOUNCE_MULTI_REPEAT_EN for hold-to-repeat.
module debounce_multi #(
  parameter int unsigned NUM_CH         = 4,
  parameter int unsigned DEBOUNCE_LIMIT = 2000000,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned REPEAT_DELAY   = 50000000,
  parameter int unsigned REPEAT_RATE    = 10000000
) (
  input  logic              i_Clk,
  input  logic              i_Rst_n,
  input  logic [NUM_CH-1:0] i_Switch,
  output logic [NUM_CH-1:0] o_Switch,
  output logic [NUM_CH-1:0] o_Rise,
  output logic [NUM_CH-1:0] o_Fall,
  output logic [NUM_CH-1:0] o_Repeat,
  output logic              o_Busy
);

  localparam int unsigned   CW     = $clog2(DEBOUNCE_LIMIT + 1);
  localparam logic [CW-1:0] CntMax = CW'(DEBOUNCE_LIMIT - 1);

  // Synchroniser chain; only the last stage feeds the debounce logic.
  logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
  logic [NUM_CH-1:0] sync_s;

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= i_Switch;
      for (int i = 1; i < int'(SYNC_STAGES); i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign sync_s = sync_q[SYNC_STAGES-1];

  logic [CW-1:0]     cnt_q [NUM_CH];
  logic [CW-1:0]     cnt_d [NUM_CH];
  logic [NUM_CH-1:0] sw_q, sw_d;
  logic [NUM_CH-1:0] accept;
  logic [NUM_CH-1:0] rise_q, rise_d;
  logic [NUM_CH-1:0] fall_q, fall_d;
  logic              busy_q, busy_d;

  // A disagreeing sample advances the counter; any agreeing sample cancels the pending change.
  always_comb begin
    sw_d   = sw_q;
    accept = '0;
    busy_d = 1'b0;
    for (int n = 0; n < int'(NUM_CH); n++) begin
      cnt_d[n] = '0;
      if (sync_s[n] != sw_q[n]) begin
        if (cnt_q[n] == CntMax) begin
          accept[n] = 1'b1;
          sw_d[n]   = sync_s[n];
        end else begin
          cnt_d[n] = cnt_q[n] + 1'b1;
        end
      end
      busy_d = busy_d | (cnt_d[n] != '0);
    end
    rise_d = accept & sync_s;
    fall_d = accept & ~sync_s;
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      for (int n = 0; n < int'(NUM_CH); n++) begin
        cnt_q[n] <= '0;
      end
      sw_q   <= '0;
      rise_q <= '0;
      fall_q <= '0;
      busy_q <= 1'b0;
    end else begin
      for (int n = 0; n < int'(NUM_CH); n++) begin
        cnt_q[n] <= cnt_d[n];
      end
      sw_q   <= sw_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      busy_q <= busy_d;
    end
  end

  assign o_Switch = sw_q;
  assign o_Rise   = rise_q;
  assign o_Fall   = fall_q;
  assign o_Busy   = busy_q;

`ifdef DEBOUNCE_MULTI_REPEAT_EN
  localparam int unsigned   RepMax     = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned   RW         = $clog2(RepMax + 1);
  localparam logic [RW-1:0] RepDelayM1 = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RepRateM1  = RW'(REPEAT_RATE - 1);

  logic [RW-1:0]     rep_q [NUM_CH];
  logic [RW-1:0]     rep_d [NUM_CH];
  logic [NUM_CH-1:0] rep_first_q, rep_first_d;
  logic [NUM_CH-1:0] repeat_q, repeat_d;

  // Count only while the level is high now and stays high next cycle, so a release
  // edge never coincides with a repeat pulse and a rise always restarts the delay.
  always_comb begin
    rep_first_d = '1;
    repeat_d    = '0;
    for (int n = 0; n < int'(NUM_CH); n++) begin
      rep_d[n] = '0;
      if (sw_q[n] && sw_d[n]) begin
        rep_first_d[n] = rep_first_q[n];
        if (rep_q[n] == (rep_first_q[n] ? RepDelayM1 : RepRateM1)) begin
          repeat_d[n]    = 1'b1;
          rep_first_d[n] = 1'b0;
        end else begin
          rep_d[n] = rep_q[n] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      for (int n = 0; n < int'(NUM_CH); n++) begin
        rep_q[n] <= '0;
      end
      rep_first_q <= '1;
      repeat_q    <= '0;
    end else begin
      for (int n = 0; n < int'(NUM_CH); n++) begin
        rep_q[n] <= rep_d[n];
      end
      rep_first_q <= rep_first_d;
      repeat_q    <= repeat_d;
    end
  end

  assign o_Repeat = repeat_q;
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^{32'(REPEAT_DELAY), 32'(REPEAT_RATE)};
  assign o_Repeat = '0;
`endif

endmodule

// File: tb/tb_debounce_multi.sv
// Directed bench for debounce_multi (2 channels, limit 8, 2 sync stages, repeat 20/5).
module tb_debounce_multi;

  logic       clk;
  logic       rst_n;
  logic [1:0] sw_in;
  logic [1:0] sw_out, rise, fall, rep;
  logic       busy;

  int errors = 0;
  int checks = 0;

  debounce_multi #(
    .NUM_CH        (2),
    .DEBOUNCE_LIMIT(8),
    .SYNC_STAGES   (2),
    .REPEAT_DELAY  (20),
    .REPEAT_RATE   (5)
  ) dut (
    .i_Clk   (clk),
    .i_Rst_n (rst_n),
    .i_Switch(sw_in),
    .o_Switch(sw_out),
    .o_Rise  (rise),
    .o_Fall  (fall),
    .o_Repeat(rep),
    .o_Busy  (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic exp_rep;
    rst_n = 1'b0;
    sw_in = 2'b11;

    // 1 reset
    for (int k = 0; k < 3; k++) begin
      tick();
      check("reset_hold", 32'({sw_out, rise, fall, rep, busy}), 32'd0);
    end
    rst_n = 1'b1;
    tick();
    check("reset_release", 32'({sw_out, rise, fall, rep, busy}), 32'd0);
    sw_in = 2'b00;
    for (int k = 0; k < 6; k++) tick();
    check("idle_level", 32'({sw_out, busy}), 32'd0);

    // 2 clean press on ch0
    sw_in = 2'b01;
    for (int k = 1; k <= 11; k++) begin
      tick();
      if (k == 3) check("press_busy", 32'(busy), 32'd1);
      if (k == 9) check("press_not_yet", 32'({sw_out, rise}), 32'd0);
      if (k == 10) check("press_edge", 32'({sw_out, rise, fall}), 32'(6'b01_01_00));
      if (k == 11) check("press_rise_width", 32'({sw_out, rise, busy}), 32'(5'b01_00_0));
    end

    // release ch0
    sw_in = 2'b00;
    for (int k = 1; k <= 11; k++) begin
      tick();
      if (k == 10) check("release_edge", 32'({sw_out, rise, fall}), 32'(6'b00_00_01));
      if (k == 11) check("release_fall_width", 32'(fall), 32'd0);
    end

    // 3 bounce: high 5, low 1, high held
    sw_in = 2'b01;
    for (int k = 0; k < 5; k++) tick();
    sw_in = 2'b00;
    tick();
    sw_in = 2'b01;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 9) check("bounce_not_yet", 32'({sw_out, rise}), 32'd0);
      if (k == 10) check("bounce_edge", 32'({sw_out, rise}), 32'(4'b01_01));
    end
    sw_in = 2'b00;
    for (int k = 0; k < 12; k++) tick();
    check("bounce_released", 32'({sw_out, busy}), 32'd0);

    // 4 glitch on ch1 one cycle short of acceptance
    sw_in = 2'b10;
    for (int k = 1; k <= 12; k++) begin
      if (k == 8) sw_in = 2'b00;
      tick();
      check("glitch_no_change", 32'({sw_out, rise, fall}), 32'd0);
      if (k == 9) check("glitch_busy", 32'(busy), 32'd1);
    end
    check("glitch_busy_clear", 32'(busy), 32'd0);

    // 5 simultaneous fall
    sw_in = 2'b11;
    for (int k = 0; k < 12; k++) tick();
    check("both_high", 32'(sw_out), 32'(2'b11));
    sw_in = 2'b00;
    for (int k = 1; k <= 11; k++) begin
      tick();
      if (k == 9) check("both_fall_not_yet", 32'({sw_out, fall}), 32'(4'b11_00));
      if (k == 10) check("both_fall_edge", 32'({sw_out, rise, fall}), 32'(6'b00_00_11));
      if (k == 11) check("both_fall_width", 32'(fall), 32'd0);
    end

    // 6 hold-to-repeat; release timed so o_Fall lands at +60
    sw_in = 2'b01;
    for (int k = 1; k <= 10; k++) tick();
    check("repeat_rise", 32'({sw_out, rise}), 32'(4'b01_01));
    for (int j = 1; j <= 75; j++) begin
      if (j == 51) sw_in = 2'b00;
      tick();
`ifdef DEBOUNCE_MULTI_REPEAT_EN
      exp_rep = (j >= 20) && (j <= 55) && ((j - 20) % 5 == 0);
`else
      exp_rep = 1'b0;
`endif
      check("repeat_pulse", 32'(rep), 32'({1'b0, exp_rep}));
      if (j == 60) check("repeat_release_fall", 32'({sw_out, fall}), 32'(4'b00_01));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
